// File: rtl/serial_bypass_subtractor.sv
// Sequential A - B - bin subtractor: computes A + ~B + ~bin two bits per cycle
// using a carry-bypass slice, with a valid/ready handshake on both sides.
module serial_bypass_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero
);

  localparam int SLICES = WIDTH / 2;
  localparam int IW     = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [IW-1:0] LAST = IW'(SLICES - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] nb_reg;
  logic [WIDTH-1:0] diff_reg;
  logic [WIDTH-1:0] diff_next;
  logic             carry_reg;
  logic [IW-1:0]    idx_reg;
  logic             bout_reg;
  logic             zero_reg;

  logic [1:0] a_slice;
  logic [1:0] b_slice;
  logic [1:0] prop;
  logic [1:0] gen;
  logic [1:0] sum;
  logic       c_mid;
  logic       ripple;
  logic       cout;

  // One 2-bit slice; when both bits propagate, the incoming carry skips the ripple path.
  always_comb begin
    a_slice   = a_reg[{idx_reg, 1'b0} +: 2];
    b_slice   = nb_reg[{idx_reg, 1'b0} +: 2];
    prop      = a_slice ^ b_slice;
    gen       = a_slice & b_slice;
    sum[0]    = prop[0] ^ carry_reg;
    c_mid     = gen[0] | (prop[0] & carry_reg);
    sum[1]    = prop[1] ^ c_mid;
    ripple    = gen[1] | (prop[1] & c_mid);
    cout      = (&prop) ? carry_reg : ripple;
    diff_next = diff_reg;
    diff_next[{idx_reg, 1'b0} +: 2] = sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      nb_reg    <= '0;
      diff_reg  <= '0;
      carry_reg <= 1'b0;
      idx_reg   <= '0;
      bout_reg  <= 1'b0;
      zero_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= A;
            nb_reg    <= ~B;
            carry_reg <= ~bin;
            idx_reg   <= '0;
            diff_reg  <= '0;
            state_reg <= RUN;
          end
        end
        RUN: begin
          diff_reg  <= diff_next;
          carry_reg <= cout;
          if (idx_reg == LAST) begin
            idx_reg   <= '0;
            bout_reg  <= ~cout;
            zero_reg  <= (diff_next == '0);
            state_reg <= DONE;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            nb_reg    <= '0;
            diff_reg  <= '0;
            carry_reg <= 1'b0;
            idx_reg   <= '0;
            bout_reg  <= 1'b0;
            zero_reg  <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // diff is built up in place during RUN, so it is only exposed once complete.
  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign diff      = out_valid ? diff_reg : '0;
  assign bout      = bout_reg;
  assign zero      = zero_reg;

endmodule

// File: tb/tb_serial_bypass_subtractor.sv
// Directed and randomised checks of serial_bypass_subtractor at WIDTH=8.
module tb_serial_bypass_subtractor;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] A;
  logic [7:0] B;
  logic       bin;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] diff;
  logic       bout;
  logic       zero;

  int n_cmp  = 0;
  int n_fail = 0;

  serial_bypass_subtractor #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bi;
    logic [7:0] d;
    logic       bo;
    logic       z;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic bi);
    A = a; B = b; bin = bi; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    A = 8'($urandom); B = 8'($urandom); bin = 1'($urandom);
    check("accept_in_ready", 32'(in_ready), 32'd0);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      check("run_diff_zero", 32'(diff), 32'd0);
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_res();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("release_idle", 32'({in_ready, out_valid}), 32'b10);
  endtask

  initial begin
    int lat;
    int got;
    int sent;
    bit accepting;
    logic [8:0] expq[$];
    logic [8:0] e;
    logic [8:0] full;

    vecs[0] = '{8'h5A, 8'h23, 1'b0, 8'h37, 1'b0, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1};
    vecs[4] = '{8'hFF, 8'h0F, 1'b0, 8'hF0, 1'b0, 1'b0};
    vecs[5] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b0, 1'b1};
    vecs[6] = '{8'h10, 8'h20, 1'b0, 8'hF0, 1'b1, 1'b0};
    vecs[7] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[8] = '{8'hAA, 8'h55, 1'b0, 8'h55, 1'b0, 1'b0};
    vecs[9] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; bin = 1'b0;
    #3;
    check("reset_outputs", 32'({in_ready, out_valid, bout, zero, diff}), 32'h800);
    #9 rst_n = 1'b1;

    // Table: odd entries also hold out_ready high during RUN, which must not matter.
    for (int i = 0; i < 10; i++) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].bi);
      out_ready = 1'(i % 2);
      wait_done(lat);
      out_ready = 1'b0;
      check("latency", 32'(lat), 32'd4);
      check("diff", 32'(diff), 32'(vecs[i].d));
      check("bout", 32'(bout), 32'(vecs[i].bo));
      check("zero", 32'(zero), 32'(vecs[i].z));
      $display("vec %0d: A=%h B=%h bin=%0d -> diff=%h bout=%0d zero=%0d lat=%0d",
               i, vecs[i].a, vecs[i].b, vecs[i].bi, diff, bout, zero, lat);
      release_res();
    end

    // Back-pressure: result must hold while inputs churn.
    start_op(8'h5A, 8'h23, 1'b0);
    wait_done(lat);
    for (int k = 0; k < 10; k++) begin
      A = 8'($urandom); B = 8'($urandom); bin = 1'($urandom); in_valid = 1'($urandom);
      @(posedge clk); #1;
      check("hold_outputs", 32'({out_valid, in_ready, bout, zero, diff}), 32'({4'b1000, 8'h37}));
    end
    A = 8'h33; B = 8'h11; bin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("release_no_accept", 32'({in_ready, out_valid}), 32'b10);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("accept_after_release", 32'(in_ready), 32'd0);
    wait_done(lat);
    check("bp_latency", 32'(lat), 32'd4);
    check("bp_diff", 32'(diff), 32'h22);
    $display("backpressure: new op diff=%h lat=%0d", diff, lat);
    release_res();

    // Reset after two slices, then a clean operation.
    start_op(8'h5A, 8'h23, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    check("midrun_reset", 32'({in_ready, out_valid, diff}), 32'h200);
    @(posedge clk); #2 rst_n = 1'b1;
    start_op(8'hFF, 8'h0F, 1'b0);
    wait_done(lat);
    check("post_reset_latency", 32'(lat), 32'd4);
    check("post_reset_diff", 32'(diff), 32'hF0);
    $display("reset recovery: diff=%h lat=%0d", diff, lat);
    release_res();

    // Randomised back-to-back stream with a scoreboard queue.
    got = 0; sent = 0;
    A = 8'($urandom); B = 8'($urandom); bin = 1'($urandom);
    in_valid = 1'b1; out_ready = 1'b1;
    for (int cyc = 0; cyc < 2000 && got < 30; cyc++) begin
      @(negedge clk);
      if (out_valid) begin
        if (expq.size() == 0) begin
          check("rand_unexpected_result", 32'd1, 32'd0);
        end else begin
          e = expq.pop_front();
          check("rand_result", 32'({bout, diff}), 32'(e));
          $display("rand %0d: diff=%h bout=%0d expected diff=%h bout=%0d", got, diff, bout, e[7:0], e[8]);
        end
        got++;
      end
      accepting = in_ready && in_valid;
      if (accepting) begin
        full = {1'b0, A} - {1'b0, B} - {8'b0, bin};
        expq.push_back(full);
        sent++;
      end
      @(posedge clk); #1;
      if (accepting) begin
        if (sent < 30) begin
          A = 8'($urandom); B = 8'($urandom); bin = 1'($urandom);
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    check("rand_result_count", 32'(got), 32'd30);
    check("rand_queue_empty", 32'(expq.size()), 32'd0);
    out_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
